// File: rtl/fp_vector_packer_if.sv
// Snoop/record bus for fp_vector_packer: fp_exe request/response taps plus the
// valid/ready record stream toward the trace consumer.
interface fp_vector_packer_if;
    logic         req_enable;
    logic [63:0]  req_data1;
    logic [63:0]  req_data2;
    logic [63:0]  req_data3;
    logic [1:0]   req_fmt;
    logic [2:0]   req_rm;
    logic [1:0]   req_op;
    logic [9:0]   req_opcode;
    logic         rsp_ready;
    logic [63:0]  rsp_result;
    logic [4:0]   rsp_flags;
    logic         rec_valid;
    logic [287:0] rec_data;
    logic         rec_ready;

    modport master (
        output req_enable, req_data1, req_data2, req_data3, req_fmt, req_rm,
               req_op, req_opcode, rsp_ready, rsp_result, rsp_flags, rec_ready,
        input  rec_valid, rec_data
    );

    modport slave (
        input  req_enable, req_data1, req_data2, req_data3, req_fmt, req_rm,
               req_op, req_opcode, rsp_ready, rsp_result, rsp_flags, rec_ready,
        output rec_valid, rec_data
    );
endinterface

// File: rtl/fp_vector_packer.sv
// Pairs fp_exe requests with their responses, packs 288-bit vector records into a FIFO.
// Optional macro FP_PACK_NAN_CANON_EN canonicalises NaN results before packing.
module fp_vector_packer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    fp_vector_packer_if.slave    bus,
    output logic                 err_overlap,
    output logic                 err_orphan,
    output logic                 err_timeout,
    output logic [CNT_W-1:0]     drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef struct packed {
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] d3;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [1:0]  op;
        logic [9:0]  opcode;
    } req_t;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_q, state_d;
    req_t          cur_q;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          capture, push, set_ovl, set_orph, set_to;
    logic [63:0]   res_w;
    logic [287:0]  rec_w;

    logic [287:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic          pop, full, wr_en, drop;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture)
                cur_q <= '{bus.req_data1, bus.req_data2, bus.req_data3, bus.req_fmt,
                           bus.req_rm, bus.req_op, bus.req_opcode};
        end
    end

    // Ready beats everything in WAIT, so a same-cycle enable chains the next request.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        push     = 1'b0;
        set_ovl  = 1'b0;
        set_orph = 1'b0;
        set_to   = 1'b0;
        case (state_q)
            IDLE: begin
                set_orph = bus.rsp_ready;
                if (bus.req_enable) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.rsp_ready) begin
                    push  = 1'b1;
                    cnt_d = '0;
                    if (bus.req_enable) capture = 1'b1;
                    else                state_d = IDLE;
                end else begin
                    set_ovl = bus.req_enable;
                    if (cnt_q == TW'(TIMEOUT - 1)) begin
                        set_to  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        res_w = bus.rsp_result;
`ifdef FP_PACK_NAN_CANON_EN
        // Integer and compare results carry no NaN semantics; leave them alone.
        if (!cur_q.opcode[9] && !cur_q.opcode[6]) begin
            if (cur_q.fmt == 2'd0 && res_w[30:23] == 8'hFF && res_w[22:0] != '0)
                res_w[31:0] = 32'h7FC0_0000;
            else if (cur_q.fmt == 2'd1 && res_w[62:52] == 11'h7FF && res_w[51:0] != '0)
                res_w = 64'h7FF8_0000_0000_0000;
        end
`endif
    end

    assign rec_w = {cur_q.d1, cur_q.d2, cur_q.d3, res_w,
                    3'b0, bus.rsp_flags, 2'b0, cur_q.fmt, 1'b0, cur_q.rm,
                    2'b0, cur_q.op, 2'b0, cur_q.opcode};

    assign full  = (occ == (AW+1)'(DEPTH));
    assign pop   = (occ != '0) && bus.rec_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= rec_w;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            drop_count  <= '0;
            err_overlap <= 1'b0;
            err_orphan  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
            if (drop && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
            if (set_ovl)  err_overlap <= 1'b1;
            if (set_orph) err_orphan  <= 1'b1;
            if (set_to)   err_timeout <= 1'b1;
        end
    end

    // Output side is purely registered state; rec_ready never reaches rec_valid.
    assign bus.rec_valid = (occ != '0);
    assign bus.rec_data  = bus.rec_valid ? mem[rd_ptr] : '0;
endmodule
